// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive frame FIFO with FWFT read, occupancy and sticky overflow
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_16bd,
    input  logic              rst,
    input  logic [8:0]        frame,
    input  logic              frame_valid,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [8:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              fv_d;
    logic              wr_evt;
    logic              rd_evt;
    logic              wr_ok;
    logic              wr_drop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign wr_evt  = frame_valid & ~fv_d;
    assign rd_evt  = rd_en & ~empty;
    // A simultaneous pop frees the slot, so a write while full is still accepted.
    assign wr_ok   = wr_evt & (~full | rd_evt);
    assign wr_drop = wr_evt & full & ~rd_evt;
    assign rd_data = empty ? 9'd0 : mem[rd_ptr];

    always_ff @(posedge clk_16bd) begin
        if (wr_ok) begin
            mem[wr_ptr] <= frame;
        end
    end

    // fv_d resets high so a strobe already asserted at reset release is not taken as an edge.
    always_ff @(posedge clk_16bd or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fv_d     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            fv_d <= frame_valid;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_evt) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_evt) begin
                count <= count + 1'b1;
            end else if (rd_evt && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART frame processor, clocked on clk_16bd.
- Captures each completed 9-bit frame when frame_valid rises.
- Stores frames in a circular FIFO until the consumer (VGA command logic) pops them.
- Provides first-word-fall-through read, occupancy count, full/empty flags and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of frame entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk_16bd  in  1  16x baud sample clock.
- rst  in  1  asynchronous, active-high reset.
- frame  in  9  received frame data from the processor; LSB = first data bit.
- frame_valid  in  1  frame-ready strobe from the processor; level, normally 1 cycle.
- rd_en  in  1  pop head entry this cycle.
- ovf_clr  in  1  clear sticky overflow.
- rd_data  out  9  head entry (FWFT); 0 when empty.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_data=0.
  - fv_d (registered frame_valid) = 1, so a frame_valid already high on reset release is not captured.
  - Memory contents are not reset.
- Write event: wr_evt = frame_valid & ~fv_d, i.e. a rising edge. fv_d <= frame_valid every cycle.
  - A frame_valid held high for N cycles produces exactly one write.
- Accepted write: mem[wr_ptr] <= frame; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - frame is sampled in the same cycle the edge is detected.
- Read event: rd_evt = rd_en & ~empty. rd_ptr <= rd_ptr+1, wrapping.
  - rd_en while empty is ignored: no pointer change, no flag change.
- rd_data is combinational: mem[rd_ptr] when ~empty, else 0.
  - Zero latency from write to visibility: the cycle after an accepted write into an empty FIFO, empty=0 and rd_data equals the written frame.
- Count update:
  - +1 on an accepted write only.
  - -1 on a read only.
  - Unchanged on simultaneous write and read, or on neither.
  - empty = (count==0); full = (count==DEPTH). Both derived from registered count.
- Full boundary:
  - wr_evt while full with no rd_evt: frame dropped, wr_ptr unchanged, overflow <= 1.
  - wr_evt while full with rd_evt in the same cycle: write accepted, read performed, count stays DEPTH, no overflow.
- Empty boundary: wr_evt and rd_en while empty: write accepted, read ignored, count becomes 1.
- Overflow flag:
  - Sticky until ovf_clr=1.
  - Set and clear in the same cycle: set wins (overflow stays 1).
  - ovf_clr has no effect on data or pointers.
- Pointer width is ADDR_W; wrap from DEPTH-1 to 0 is natural overflow of the counter.
- Reset mid-operation: all state returns to reset values immediately; buffered frames are discarded; a frame_valid high at release is ignored per the fv_d=1 rule.
- No combinational path from frame or frame_valid to any output. Only rd_data depends combinationally on registered pointers and memory.

Test Plan:
1. Reset, then frame=0x0A5 with a 1-cycle frame_valid → next cycle empty=0, count=1, rd_data=0x0A5. Pulse rd_en → empty=1, rd_data=0, count=0.
2. frame=0x155 with frame_valid held 5 cycles → count=1 only. A second 1-cycle pulse with 0x001 → count=2; pops return 0x155 then 0x001.
3. Write 16 frames 0x000..0x00F → full=1, count=16. 17th frame 0x1FF → dropped, overflow=1, count=16. Drain 16 → data 0x000..0x00F in order, wrap verified. Refill 3 and drain to confirm pointer wrap-around.
4. With full=1, assert a frame_valid edge (0x123) and rd_en in the same cycle → overflow stays 0, count=16, popped 0x000, and 0x123 appears last on drain.
5. Empty FIFO, rd_en=1 for 3 cycles → count=0, empty=1, no underflow side effects. Then rd_en and a frame_valid edge together → count=1.
6. Overflow set, then ovf_clr in the same cycle as another dropped write → overflow=1; ovf_clr alone next cycle → overflow=0. Assert rst with count=5 and frame_valid high through reset release → count=0, no capture until the next rising edge.
